npu_sram_operand_reader: RTL and testbench

- Read-side DMA stage directly upstream of the NPU compute path. It consumes the second port of the 4096x16 on-chip operand SRAM.
- On a start command, it reads `length` words beginning at `base_addr` with a programmable stride and wraps addresses modulo 4096.
- Words are presented on a valid/ready stream to the MAC array.
- The SRAM port has 1-cycle read latency (registered address, unregistered q). The block absorbs this latency and downstream backpressure with a 2-entry output FIFO, sustaining 1 word/cycle.

---
 rtl/npu_sram_operand_reader_if.sv | 39 +++
 rtl/npu_sram_operand_reader.sv | 179 +++++++++++++++++
 tb/tb_npu_sram_operand_reader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_sram_operand_reader_if.sv
// Command, SRAM-port and output-stream signals of the operand reader.
// The slave modport is the reader's view; master is the surrounding system's view.
interface npu_sram_operand_reader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 13
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  length;
  logic              clear;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] sram_address;
  logic              sram_chipselect;
  logic              sram_write;
  logic [1:0]        sram_byteenable;
  logic              sram_clken;
  logic [DATA_W-1:0] sram_readdata;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output start, base_addr, stride, length, clear, sram_readdata, out_ready,
    input  busy, done, sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  start, base_addr, stride, length, clear, sram_readdata, out_ready,
    output busy, done, sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/npu_sram_operand_reader.sv
// Strided SRAM read DMA feeding a valid/ready stream. A 2-entry first-word-fall-through
// FIFO absorbs the 1-cycle SRAM read latency and downstream backpressure at 1 word/cycle.
module npu_sram_operand_reader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 13
) (
  input logic                      clk,
  input logic                      reset_n,
  npu_sram_operand_reader_if.slave bus_io
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(2 ** ADDR_W);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  accepted_q, accepted_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d;
  logic              tail_last_q, tail_last_d;
  logic [1:0]        count_q, count_d;

  logic [LEN_W-1:0]  len_clamped;
  logic              out_valid;
  logic              pop;
  logic              push;
  logic [1:0]        occ_next;
  logic              issue;
  logic              last_issue;

  assign len_clamped = (bus_io.length > MaxLen) ? MaxLen : bus_io.length;
  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid & bus_io.out_ready;
  assign push        = inflight_q;
  // Occupancy once this cycle's pop and the returning read are both accounted for.
  assign occ_next    = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue       = (state_q == StRun) && (occ_next < 2'd2);
  assign last_issue  = issue && (issued_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    if (pop) begin
      accepted_d = accepted_q + LEN_W'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          addr_d     = bus_io.base_addr;
          stride_d   = bus_io.stride;
          len_d      = len_clamped;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (len_clamped == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + LEN_W'(1);
        end
        if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && (accepted_q == len_q - LEN_W'(1))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus_io.clear) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    head_data_d     = head_data_q;
    head_last_d     = head_last_q;
    tail_data_d     = tail_data_q;
    tail_last_d     = tail_last_q;
    count_d         = count_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = bus_io.sram_readdata;
          head_last_d = inflight_last_q;
        end else begin
          tail_data_d = bus_io.sram_readdata;
          tail_last_d = inflight_last_q;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = bus_io.sram_readdata;
          head_last_d = inflight_last_q;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = bus_io.sram_readdata;
          tail_last_d = inflight_last_q;
        end
      end
      default: ;
    endcase
    // Abort drops both buffered words and the read still returning from the SRAM.
    if (bus_io.clear) begin
      count_d         = 2'd0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      stride_q        <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      accepted_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_data_q     <= '0;
      head_last_q     <= 1'b0;
      tail_data_q     <= '0;
      tail_last_q     <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      stride_q        <= stride_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      accepted_q      <= accepted_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_data_q     <= head_data_d;
      head_last_q     <= head_last_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
      count_q         <= count_d;
    end
  end

  assign bus_io.busy            = (state_q == StRun) || (state_q == StDrain);
  assign bus_io.done            = (state_q == StDone);
  assign bus_io.sram_address    = addr_q;
  assign bus_io.sram_chipselect = issue;
  assign bus_io.sram_write      = 1'b0;
  assign bus_io.sram_byteenable = 2'b11;
  assign bus_io.sram_clken      = 1'b1;
  assign bus_io.out_data        = head_data_q;
  assign bus_io.out_valid       = out_valid;
  assign bus_io.out_last        = out_valid & head_last_q;

endmodule

// File: tb/tb_npu_sram_operand_reader.sv
// Bench for npu_sram_operand_reader: queue-based transfer model checked every cycle,
// directed scenarios with literal expectations, then randomized transfers.
module tb_npu_sram_operand_reader;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned LW    = 13;
  localparam int unsigned Words = 4096;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  npu_sram_operand_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  npu_sram_operand_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  logic [DW-1:0] mem [Words];
  always @(posedge clk) if (bus.sram_chipselect) bus.sram_readdata <= mem[bus.sram_address];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Ready pattern: 0 always high, 1 random, 2 repeating 1,0,0, 3 always low.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      2:       bus.out_ready = (cyc % 3 == 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Transfer model: 0 idle, 1 run, 2 drain, 3 done.
  int          m_state = 0;
  int unsigned m_base, m_stride, m_len, m_issued, m_acc;
  word_t       m_fifo[$];
  bit          m_infl = 0;
  word_t       m_infl_word;

  int unsigned cs_addr[$];
  int          cs_rel[$];
  word_t       acc_w[$];
  int          acc_rel[$];
  int          done_rel;
  int          done_cnt;
  int          start_cyc;

  bit          e_valid, e_pop, e_cs;
  int          e_occ;
  int unsigned e_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_cs", bus.sram_chipselect, 0);
      check("rst_addr", bus.sram_address, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_data", bus.out_data, 0);
      m_state = 0;
      m_fifo.delete();
      m_infl = 0;
      m_issued = 0;
      m_acc = 0;
    end else begin
      e_valid = (m_fifo.size() > 0);
      e_pop   = e_valid && bus.out_ready;
      e_occ   = m_fifo.size() - int'(e_pop) + int'(m_infl);
      e_cs    = (m_state == 1) && (e_occ < 2);
      e_addr  = (m_base + m_issued * m_stride) % Words;
      check("busy", bus.busy, (m_state == 1) || (m_state == 2));
      check("done", bus.done, m_state == 3);
      check("out_valid", bus.out_valid, e_valid);
      if (e_valid) begin
        check("out_data", bus.out_data, m_fifo[0].data);
        check("out_last", bus.out_last, m_fifo[0].last);
      end
      check("chipselect", bus.sram_chipselect, e_cs);
      if (e_cs) check("sram_address", bus.sram_address, e_addr);
      check("sram_ctl", {bus.sram_write, bus.sram_byteenable, bus.sram_clken}, 4'b0111);

      if (bus.sram_chipselect) begin
        cs_addr.push_back(bus.sram_address);
        cs_rel.push_back(cyc - start_cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        acc_w.push_back({bus.out_last, bus.out_data});
        acc_rel.push_back(cyc - start_cyc);
      end
      if (bus.done) begin
        done_rel = cyc - start_cyc;
        done_cnt++;
      end

      if (bus.clear) begin
        m_state = 0;
        m_fifo.delete();
        m_infl = 0;
      end else begin
        if (e_pop) begin
          void'(m_fifo.pop_front());
          m_acc++;
        end
        if (m_infl) begin
          check("fifo_no_overflow", m_fifo.size() < 2, 1);
          m_fifo.push_back(m_infl_word);
        end
        m_infl = 0;
        if (e_cs) begin
          m_infl = 1;
          m_infl_word = {m_issued == m_len - 1, mem[e_addr]};
          m_issued++;
        end
        case (m_state)
          0: if (bus.start) begin
            m_base   = bus.base_addr;
            m_stride = bus.stride;
            m_len    = (bus.length > Words) ? Words : bus.length;
            m_issued = 0;
            m_acc    = 0;
            m_state  = (m_len == 0) ? 3 : 1;
          end
          1: if (m_issued == m_len) m_state = 2;
          2: if (m_acc == m_len) m_state = 3;
          default: m_state = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int unsigned b, input int unsigned s, input int unsigned l);
    cs_addr.delete();
    cs_rel.delete();
    acc_w.delete();
    acc_rel.delete();
    done_cnt = 0;
    done_rel = -1;
    start_cyc = cyc;
    bus.base_addr = AW'(b);
    bus.stride = AW'(s);
    bus.length = LW'(l);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      tick();
      i++;
    end
    check({name, "_done_seen"}, done_cnt > 0, 1);
    tick();
  endtask

  int unsigned exp2[3];
  int unsigned rb, rs, rl, ea;
  int          clr_at;
  bit          cleared;

  initial begin
    for (int i = 0; i < Words; i++) mem[i] = DW'($urandom);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.base_addr = '0;
    bus.stride = '0;
    bus.length = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Basic 4-word transfer, cycle-exact against hand-derived timing.
    ready_mode = 0;
    pulse_start(12'h010, 1, 4);
    wait_done(30, "t1");
    check("t1_n_issue", cs_addr.size(), 4);
    for (int i = 0; i < cs_addr.size() && i < 4; i++) begin
      check("t1_addr", cs_addr[i], 12'h010 + i);
      check("t1_cs_cycle", cs_rel[i], i + 1);
    end
    check("t1_n_accept", acc_w.size(), 4);
    for (int i = 0; i < acc_w.size() && i < 4; i++) begin
      check("t1_data", acc_w[i].data, mem[12'h010 + i]);
      check("t1_last", acc_w[i].last, i == 3);
      check("t1_acc_cycle", acc_rel[i], i + 3);
    end
    check("t1_done_cycle", done_rel, 7);

    // Address wrap.
    exp2 = '{12'hFFE, 12'h001, 12'h004};
    pulse_start(12'hFFE, 3, 3);
    wait_done(30, "t2");
    check("t2_n_issue", cs_addr.size(), 3);
    check("t2_n_accept", acc_w.size(), 3);
    for (int i = 0; i < 3 && i < cs_addr.size() && i < acc_w.size(); i++) begin
      check("t2_addr", cs_addr[i], exp2[i]);
      check("t2_data", acc_w[i].data, mem[exp2[i]]);
    end

    // Backpressure pattern: issues must stall and order must hold.
    ready_mode = 2;
    pulse_start(12'h200, 5, 8);
    wait_done(100, "t3");
    check("t3_n_accept", acc_w.size(), 8);
    for (int i = 0; i < acc_w.size() && i < 8; i++)
      check("t3_data", acc_w[i].data, mem[(12'h200 + 5 * i) % Words]);
    check("t3_n_issue", cs_addr.size(), 8);
    if (cs_rel.size() == 8) check("t3_stalled", (cs_rel[7] - cs_rel[0]) > 7, 1);

    // Zero length: no SRAM access, done straight after the start.
    ready_mode = 0;
    pulse_start(12'h123, 1, 0);
    wait_done(10, "t4");
    check("t4_n_issue", cs_addr.size(), 0);
    check("t4_done_cycle", done_rel, 1);

    // Start while busy is ignored.
    ready_mode = 1;
    pulse_start(12'h100, 2, 6);
    tick();
    tick();
    bus.base_addr = 12'h800;
    bus.stride = 12'd7;
    bus.length = 13'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(100, "t5");
    check("t5_n_issue", cs_addr.size(), 6);
    if (cs_addr.size() == 6) check("t5_last_addr", cs_addr[5], 12'h10A);
    check("t5_n_accept", acc_w.size(), 6);

    // Clear with a buffered word and a read in flight, then reset mid-run.
    ready_mode = 3;
    pulse_start(12'h300, 1, 10);
    tick();
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("t6_valid_after_clear", bus.out_valid, 0);
    check("t6_busy_after_clear", bus.busy, 0);
    tick();
    check("t6_inflight_dropped", bus.out_valid, 0);
    ready_mode = 1;
    pulse_start(12'h400, 3, 10);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_busy_after_reset", bus.busy, 0);
    check("t6_valid_after_reset", bus.out_valid, 0);
    ready_mode = 0;
    pulse_start(12'h7F0, 12'h020, 2);
    wait_done(30, "t6");
    check("t6_n_accept", acc_w.size(), 2);
    if (acc_w.size() == 2) begin
      check("t6_data0", acc_w[0], {1'b0, mem[12'h7F0]});
      check("t6_data1", acc_w[1], {1'b1, mem[12'h810]});
    end

    // Length above the maximum is clamped to a full-memory sweep.
    pulse_start(12'h555, 1, 5000);
    wait_done(4400, "t7");
    check("t7_n_issue", cs_addr.size(), Words);
    if (cs_addr.size() == Words) check("t7_last_addr", cs_addr[Words-1], 12'h554);
    check("t7_n_accept", acc_w.size(), Words);

    // Randomized transfers with stray starts and occasional aborts.
    for (int t = 0; t < 40; t++) begin
      ready_mode = $urandom_range(0, 2);
      rb = $urandom_range(0, Words - 1);
      rs = $urandom_range(0, Words - 1);
      rl = $urandom_range(0, 20);
      clr_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
      cleared = 0;
      pulse_start(rb, rs, rl);
      for (int c = 1; c < 400 && done_cnt == 0 && !cleared; c++) begin
        if (c == clr_at) begin
          bus.clear = 1'b1;
          cleared = 1;
        end else if ((m_state == 1 || m_state == 2) && $urandom_range(0, 7) == 0) begin
          bus.base_addr = AW'($urandom);
          bus.stride = AW'($urandom);
          bus.length = LW'($urandom_range(1, 30));
          bus.start = 1'b1;
        end
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
      end
      if (!cleared) begin
        check("rnd_done_seen", done_cnt > 0, 1);
        check("rnd_n_accept", acc_w.size(), rl);
        for (int i = 0; i < acc_w.size() && i < rl; i++) begin
          ea = (rb + i * rs) % Words;
          check("rnd_data", acc_w[i], {i == rl - 1, mem[ea]});
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
